// File: rtl/colpar_pkg.sv
// Shared types and default sizing for the column-parity row packer.
package colpar_pkg;

  localparam int unsigned ROW_W_DEF = 64;
  localparam int unsigned DEPTH_DEF = 4;

  typedef enum logic {
    CAPTURE = 1'b0,
    DONE    = 1'b1
  } state_e;

endpackage

// File: rtl/colpar_row_fifo.sv
// Row FIFO: DEPTH entries of W bits, head entry driven straight from storage.
module colpar_row_fifo #(
  parameter int unsigned W     = 72,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         push_ok_o,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop_eff;
  logic          push_ok;

  assign valid_o = (cnt_q != '0);
  assign pop_eff = pop_i & valid_o;

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok   = push_i & ((cnt_q < CW'(DEPTH)) | pop_eff);
  assign push_ok_o = push_ok;

  // Gate the head so stale storage never shows while empty.
  assign data_o = valid_o ? mem_q[rd_q] : '0;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      wr_d = wr_q + PW'(1);
    end
    if (pop_eff) begin
      rd_d = rd_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/colpar_row_packer.sv
// Packs a qualified serial bit stream into right-justified rows and buffers them in a FIFO.
module colpar_row_packer
  import colpar_pkg::*;
#(
  parameter int unsigned ROW_W = ROW_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         pin,
  input  logic                         co,
  input  logic                         co64,
  output logic [ROW_W-1:0]             row_data,
  output logic [$clog2(ROW_W+1)-1:0]   row_len,
  output logic                         row_last,
  output logic                         row_valid,
  input  logic                         row_ready,
  output logic                         overflow,
  output logic                         frame_done
);

  localparam int unsigned LW = $clog2(ROW_W + 1);
  localparam int unsigned FW = ROW_W + LW + 1;

  state_e          state_q, state_d;
  logic [ROW_W-1:0] acc_q, acc_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic [ROW_W-1:0] acc_nx;
  logic [LW-1:0]   cnt_nx;
  logic            push;
  logic            push_last;
  logic [FW-1:0]   push_data;
  logic            push_ok;
  logic [FW-1:0]   head;

  assign acc_nx = {acc_q[ROW_W-2:0], pin};
  assign cnt_nx = cnt_q + LW'(1'b1);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    push_last = 1'b0;
    push_data = '0;
    if (state_q == CAPTURE && en) begin
      acc_d = acc_nx;
      cnt_d = cnt_nx;
      // Explicit co or a full accumulator both close the row; co64 only counts with co.
      if (co || cnt_nx == LW'(ROW_W)) begin
        push      = 1'b1;
        push_last = co & co64;
        push_data = {push_last, cnt_nx, acc_nx};
        acc_d     = '0;
        cnt_d     = '0;
        if (push_last) begin
          state_d = DONE;
        end
      end
    end
    if (push && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CAPTURE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  colpar_row_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .data_i    (push_data),
    .pop_i     (row_ready),
    .push_ok_o (push_ok),
    .valid_o   (row_valid),
    .data_o    (head)
  );

  assign row_data   = head[ROW_W-1:0];
  assign row_len    = head[ROW_W +: LW];
  assign row_last   = head[FW-1];
  assign overflow   = ovf_q;
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_colpar_row_packer.sv
// Bench for colpar_row_packer at ROW_W=8, DEPTH=4: vector table plus corner-case sequences.
module tb_colpar_row_packer;

  localparam int unsigned ROW_W = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0, pin = 1'b0, co = 1'b0, co64 = 1'b0;
  logic             row_ready = 1'b0;
  logic [ROW_W-1:0] row_data;
  logic [LW-1:0]    row_len;
  logic             row_last, row_valid, overflow, frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0]  seq;
    int unsigned n;
    logic [7:0]  exp_data;
    logic [3:0]  exp_len;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    logic       last;
  } row_t;

  row_t exp_q[$];
  vec_t vecs[6];

  colpar_row_packer #(
    .ROW_W (ROW_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pin        (pin),
    .co         (co),
    .co64       (co64),
    .row_data   (row_data),
    .row_len    (row_len),
    .row_last   (row_last),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic p, input logic c, input logic c64);
    en = 1'b1; pin = p; co = c; co64 = c64;
    tick();
    en = 1'b0; pin = 1'b0; co = 1'b0; co64 = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [3:0] l, input logic last);
    row_t r;
    r.data = d; r.len = l; r.last = last;
    exp_q.push_back(r);
  endtask

  task automatic check_head(input string tag);
    row_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(row_valid), 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(row_valid), 32'd1);
      chk({tag, "_data"},  32'(row_data),  32'(e.data));
      chk({tag, "_len"},   32'(row_len),   32'(e.len));
      chk({tag, "_last"},  32'(row_last),  32'(e.last));
    end
  endtask

  task automatic drain(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      check_head(tag);
      row_ready = 1'b1;
      tick();
      row_ready = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(row_valid),  32'd0);
    chk("rst_data",  32'(row_data),   32'd0);
    chk("rst_len",   32'(row_len),    32'd0);
    chk("rst_last",  32'(row_last),   32'd0);
    chk("rst_ovf",   32'(overflow),   32'd0);
    chk("rst_done",  32'(frame_done), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{10'b1011,     4, 8'h0B, 4'd4};
    vecs[1] = '{10'b1,        1, 8'h01, 4'd1};
    vecs[2] = '{10'b0,        1, 8'h00, 4'd1};
    vecs[3] = '{10'b10100101, 8, 8'hA5, 4'd8};
    vecs[4] = '{10'b100,      3, 8'h04, 4'd3};
    vecs[5] = '{10'b0110,     4, 8'h06, 4'd4};

    apply_reset();

    // Table of single rows: commit, latency check, pop, empty check.
    for (int unsigned v = 0; v < 6; v++) begin
      logic [9:0] s;
      s = vecs[v].seq;
      push_exp(vecs[v].exp_data, vecs[v].exp_len, 1'b0);
      for (int unsigned b = 0; b < vecs[v].n; b++) begin
        chk("vec_pre_valid", 32'(row_valid), 32'd0);
        send_bit(s[vecs[v].n - 1 - b], (b == vecs[v].n - 1), 1'b0);
      end
      drain("vec", 1);
      chk("vec_post_valid", 32'(row_valid), 32'd0);
    end

    // Ten ones without co: auto-commit at 8 bits, remainder waits for co.
    for (int unsigned i = 0; i < 10; i++) begin
      if (i == 7) push_exp(8'hFF, 4'd8, 1'b0);
      if (i == 9) push_exp(8'h03, 4'd2, 1'b0);
      send_bit(1'b1, (i == 9), 1'b0);
      if (i == 7) chk("auto_valid", 32'(row_valid), 32'd1);
      if (i == 8) chk("auto_ovf", 32'(overflow), 32'd0);
    end
    drain("auto", 2);
    chk("auto_empty", 32'(row_valid), 32'd0);

    // Five rows into a depth-4 FIFO with no reader.
    for (int unsigned r = 0; r < 5; r++) begin
      logic [1:0] rb;
      rb = 2'(r);
      if (r < 4) push_exp({6'd0, rb}, 4'd2, 1'b0);
      send_bit(rb[1], 1'b0, 1'b0);
      send_bit(rb[0], 1'b1, 1'b0);
    end
    chk("ovf_set", 32'(overflow), 32'd1);
    drain("ovf", 4);
    chk("ovf_empty", 32'(row_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset mid-row with two rows buffered.
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    chk("arst_pre_valid", 32'(row_valid), 32'd1);
    rst = 1'b1;
    #2;
    chk("arst_valid", 32'(row_valid),  32'd0);
    chk("arst_ovf",   32'(overflow),   32'd0);
    chk("arst_done",  32'(frame_done), 32'd0);
    chk("arst_data",  32'(row_data),   32'd0);
    rst = 1'b0;
    exp_q.delete();
    push_exp(8'h02, 4'd2, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    drain("arst", 1);
    chk("arst_empty", 32'(row_valid), 32'd0);

    // Full FIFO with pop and push on the same edge.
    apply_reset();
    for (int unsigned r = 1; r <= 4; r++) begin
      logic [2:0] rb;
      rb = 3'(r);
      push_exp({5'd0, rb}, 4'd3, 1'b0);
      send_bit(rb[2], 1'b0, 1'b0);
      send_bit(rb[1], 1'b0, 1'b0);
      send_bit(rb[0], 1'b1, 1'b0);
    end
    check_head("simul_head");
    push_exp(8'h01, 4'd1, 1'b0);
    row_ready = 1'b1;
    send_bit(1'b1, 1'b1, 1'b0);
    row_ready = 1'b0;
    chk("simul_ovf", 32'(overflow), 32'd0);
    drain("simul", 4);
    chk("simul_empty", 32'(row_valid), 32'd0);

    // End of frame: co64 alone ignored, co+co64 closes the frame.
    apply_reset();
    push_exp(8'h06, 4'd3, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
    chk("co64_alone_done", 32'(frame_done), 32'd0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b1, 1'b1);
    chk("frame_done", 32'(frame_done), 32'd1);
    for (int unsigned i = 0; i < 6; i++) begin
      send_bit(1'b1, 1'b1, 1'(i % 2));
    end
    chk("done_ovf", 32'(overflow), 32'd0);
    drain("frame", 1);
    chk("frame_empty", 32'(row_valid), 32'd0);
    chk("frame_hold", 32'(frame_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/colpar_row_packer.md
COLPAR_ROW_PACKER -- requirements
Module: colpar_row_packer

Interface
REQ-001 Parameter ROW_W, default 64, SHALL set the maximum bits per row (ROW_W >= 2).
REQ-002 Parameter DEPTH, default 4, SHALL set the row FIFO depth, a power of two >= 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 en  input  1  SHALL qualify pin, co and co64; all three are ignored when en=0.
REQ-006 pin  input  1  SHALL carry the serial data bit.
REQ-007 co  input  1  SHALL mark the current bit as the last bit of a row.
REQ-008 co64  input  1  SHALL mark end of frame; it is honoured only together with co.
REQ-009 row_data  output  ROW_W  SHALL be the FIFO-head row, right-justified, with unused upper bits zero.
REQ-010 row_len  output  $clog2(ROW_W+1)  SHALL give the number of valid bits in row_data.
REQ-011 row_last  output  1  SHALL flag the head row as the final row of the frame.
REQ-012 row_valid  output  1  SHALL be high whenever the FIFO is non-empty.
REQ-013 row_ready  input  1  SHALL pop the head row when sampled high with row_valid high.
REQ-014 overflow  output  1  SHALL be a sticky flag that a committed row was dropped.
REQ-015 frame_done  output  1  SHALL be high in state DONE.

Function
REQ-016 The FSM SHALL have two states, CAPTURE and DONE, and SHALL leave reset in CAPTURE.
REQ-017 In CAPTURE with en=1, pin SHALL shift into the accumulator LSB-side, so the first bit of a row ends at row_data[len-1].
REQ-018 A bit with en=1 and co=1 SHALL commit the accumulator, including that bit, as a row of length count+1.
REQ-019 A bit that brings the count to ROW_W without co SHALL auto-commit a full row with row_len=ROW_W, row_last=0; the next bit starts a new row.
REQ-020 A commit SHALL clear the accumulator and bit count in the same edge.
REQ-021 A commit with co64=1 SHALL set row_last=1 on that row and move the FSM to DONE.
REQ-022 co64=1 with co=0 SHALL be ignored.
REQ-023 In DONE, en, pin, co and co64 SHALL be ignored; the FIFO SHALL keep draining; DONE is left only by reset.
REQ-024 A row committed on edge N SHALL be visible at the FIFO output after edge N when the FIFO was empty, giving 1-cycle latency.
REQ-025 A push SHALL be accepted when FIFO occupancy < DEPTH, or when occupancy = DEPTH and a pop occurs on the same edge.
REQ-026 A rejected push SHALL drop the row, set overflow, and still clear the accumulator.
REQ-027 A simultaneous push and pop on an empty FIFO SHALL be impossible, because row_valid=0; the row SHALL be pushed.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a counter of width $clog2(DEPTH)+1.
REQ-029 Outputs SHALL be registered or driven directly from FIFO storage, with no combinational path from pin to row_data.

Reset
REQ-030 While rst=1: state=CAPTURE, accumulator=0, bit count=0, FIFO empty, row_valid=0, row_data=0, row_len=0, row_last=0, overflow=0, frame_done=0.
REQ-031 Reset asserted mid-row or mid-drain SHALL discard all partial and buffered rows without emitting them.

Structure
REQ-032 Package colpar_pkg SHALL hold the FSM state typedef and the default ROW_W and DEPTH constants.
REQ-033 The row FIFO SHALL be a sub-module colpar_row_fifo, parametrised by data width ROW_W+len width+1 and by DEPTH.

Verification
REQ-034 ROW_W=8: bits 1,0,1,1 with co on the 4th -> one row, row_data=8'h0B, row_len=4, row_last=0, row_valid high one cycle after commit.
REQ-035 ROW_W=8: 10 bits with no co, all 1 -> first row 8'hFF with row_len=8; the remaining 2 bits are held until co, then emitted as row_data=8'h03, row_len=2.
REQ-036 DEPTH=4, row_ready=0: commit 5 rows -> 4 rows buffered, overflow=1; assert row_ready -> the 4 original rows come out in order.
REQ-037 FIFO full with row_ready=1 and a commit on the same edge -> push accepted, overflow stays 0, occupancy stays 4.
REQ-038 co+co64 on a 3-bit row 1,1,0 -> row_data=8'h06, row_last=1, frame_done=1; further en/pin activity adds no rows.
REQ-039 rst pulse mid-row with 2 rows buffered -> row_valid=0, overflow=0, frame_done=0 immediately (asynchronously); the next row starts clean.
